// File: rtl/regfile_sb_pkg.sv
// regfile_pkg: shared defaults, types and helpers for the scoreboarded
// register file (regfile_sb) and its pending-write scoreboard.
//   DATA_W_DEF / ADDR_W_DEF / PEND_W_DEF : default parameter values
//   reg_addr_t / word_t                  : default-width address / data types
//   pend_max()                           : largest value a pending counter holds
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned PEND_W_DEF = 2;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

  // Maximum number of in-flight writes a PEND_W-bit counter can track.
  function automatic int unsigned pend_max(input int unsigned pend_w);
    return (32'd1 << pend_w) - 32'd1;
  endfunction

endpackage

// File: rtl/regfile_sb_pend_scoreboard.sv
// pend_scoreboard: per-register pending-write counters for regfile_sb.
// Decode reserves a destination on issue, writeback releases one
// reservation per write. Generates source hazards and issue readiness.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ra1, ra2          read (source) addresses to hazard-check
//   we, wa            writeback enable/address (retires one reservation)
//   iss_valid,iss_dst issue request and destination to reserve
//   haz1, haz2        source has an outstanding write not yet available
//   iss_ready         iss_dst can accept another reservation
//   err_underflow     sticky: a retire found its counter already at 0
module pend_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned PEND_W   = PEND_W_DEF,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dst,
  output logic              haz1,
  output logic              haz2,
  output logic              iss_ready,
  output logic              err_underflow
);

  localparam int unsigned     NUM_REGS = 2 ** ADDR_W;
  localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(pend_max(PEND_W));
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [PEND_W-1:0] cnt [NUM_REGS];

  logic ra1_zero, ra2_zero, wa_zero, dst_zero;
  logic retire, issue;

  always_comb begin
    ra1_zero = (ZERO_REG != 0) && (ra1 == '0);
    ra2_zero = (ZERO_REG != 0) && (ra2 == '0);
    wa_zero  = (ZERO_REG != 0) && (wa == '0);
    dst_zero = (ZERO_REG != 0) && (iss_dst == '0);
  end

  // A retire to iss_dst frees a slot in the same cycle, so a full counter
  // can still accept an issue when it is being retired concurrently.
  always_comb begin
    iss_ready = dst_zero || (cnt[iss_dst] != CNT_MAX) || (we && (wa == iss_dst));
    retire    = we && !wa_zero;
    issue     = iss_valid && iss_ready && !dst_zero;
  end

  // With bypass, the last outstanding write being retired this cycle is
  // forwarded on the read port, so it no longer counts as a hazard.
  always_comb begin
    haz1 = !ra1_zero && (cnt[ra1] != '0) &&
           !((BYPASS != 0) && we && (wa == ra1) && (cnt[ra1] == CNT_ONE));
    haz2 = !ra2_zero && (cnt[ra2] != '0) &&
           !((BYPASS != 0) && we && (wa == ra2) && (cnt[ra2] == CNT_ONE));
  end

  // Retire is applied before issue: a retire at 0 saturates to 0, and a
  // concurrent issue then brings the counter to 1.
  function automatic logic [PEND_W-1:0] next_cnt(input logic [PEND_W-1:0] cur,
                                                 input logic dec,
                                                 input logic inc);
    logic [PEND_W-1:0] after_dec;
    after_dec = (dec && (cur != '0)) ? cur - CNT_ONE : cur;
    return inc ? after_dec + CNT_ONE : after_dec;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        cnt[i] <= '0;
      end
      err_underflow <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        cnt[i] <= next_cnt(cnt[i],
                           retire && (wa == ADDR_W'(i)),
                           issue && (iss_dst == ADDR_W'(i)));
      end
      if (retire && (cnt[wa] == '0)) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with two combinational read
// ports, one write port, optional write-to-read bypass and a per-register
// pending-write scoreboard (pend_scoreboard).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ra1/rd1, ra2/rd2  read address / data, zero-latency
//   haz1, haz2        source has an outstanding write not yet available
//   we, wa, wd        writeback enable/address/data; also retires wa
//   iss_valid,iss_dst decode reserves iss_dst
//   iss_ready         iss_dst can accept another reservation
//   err_underflow     sticky retire-at-zero error
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned PEND_W   = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              haz1,
  output logic              haz2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dst,
  output logic              iss_ready,
  output logic              err_underflow
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic ra1_zero, ra2_zero, wa_zero, wr_en, fwd1, fwd2;

  always_comb begin
    ra1_zero = (ZERO_REG != 0) && (ra1 == '0);
    ra2_zero = (ZERO_REG != 0) && (ra2 == '0);
    wa_zero  = (ZERO_REG != 0) && (wa == '0);
    wr_en    = we && !wa_zero;
    // Forwarding is suppressed during reset so reads stay at 0.
    fwd1     = (BYPASS != 0) && rst_n && wr_en && (wa == ra1);
    fwd2     = (BYPASS != 0) && rst_n && wr_en && (wa == ra2);
  end

  always_comb begin
    if (ra1_zero)  rd1 = '0;
    else if (fwd1) rd1 = wd;
    else           rd1 = regs[ra1];
    if (ra2_zero)  rd2 = '0;
    else if (fwd2) rd2 = wd;
    else           rd2 = regs[ra2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  pend_scoreboard #(
    .ADDR_W   (ADDR_W),
    .PEND_W   (PEND_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .ra1           (ra1),
    .ra2           (ra2),
    .we            (we),
    .wa            (wa),
    .iss_valid     (iss_valid),
    .iss_dst       (iss_dst),
    .haz1          (haz1),
    .haz2          (haz2),
    .iss_ready     (iss_ready),
    .err_underflow (err_underflow)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (DATA_W=32, ADDR_W=5, ZERO_REG=1,
// BYPASS=1, PEND_W=2). A reference model holds register contents,
// pending-write counts and the sticky error as plain arrays/integers.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa, iss_dst;
  logic [31:0] rd1, rd2, wd;
  logic        haz1, haz2, we, iss_valid, iss_ready, err_underflow;

  regfile_sb #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .ZERO_REG (1),
    .BYPASS   (1),
    .PEND_W   (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ra1           (ra1),
    .ra2           (ra2),
    .rd1           (rd1),
    .rd2           (rd2),
    .haz1          (haz1),
    .haz2          (haz2),
    .we            (we),
    .wa            (wa),
    .wd            (wd),
    .iss_valid     (iss_valid),
    .iss_dst       (iss_dst),
    .iss_ready     (iss_ready),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] regs_m [32];
  int          cnt_m  [32];
  bit          uf_m;
  localparam int MAXP = 3;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      regs_m[i] = '0;
      cnt_m[i]  = 0;
    end
    uf_m = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (ra == 5'd0) return 32'd0;
    if (we && wa == ra) return wd;
    return regs_m[ra];
  endfunction

  // Outstanding writes still not delivered after this cycle's retire.
  function automatic logic exp_haz(input logic [4:0] ra);
    int left;
    if (ra == 5'd0) return 1'b0;
    left = cnt_m[ra] - ((we && wa == ra) ? 1 : 0);
    return left > 0;
  endfunction

  function automatic logic exp_rdy();
    if (iss_dst == 5'd0) return 1'b1;
    return (cnt_m[iss_dst] - ((we && wa == iss_dst) ? 1 : 0)) < MAXP;
  endfunction

  task automatic apply(input logic [4:0] a1, input logic [4:0] a2,
                       input logic w, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic iv, input logic [4:0] dst);
    @(negedge clk);
    ra1 = a1; ra2 = a2; we = w; wa = waddr; wd = wdata;
    iss_valid = iv; iss_dst = dst;
    #1;
    chk("rd1", rd1, exp_rd(ra1));
    chk("rd2", rd2, exp_rd(ra2));
    chk("haz1", {31'd0, haz1}, {31'd0, exp_haz(ra1)});
    chk("haz2", {31'd0, haz2}, {31'd0, exp_haz(ra2)});
    chk("iss_ready", {31'd0, iss_ready}, {31'd0, exp_rdy()});
  endtask

  task automatic tick();
    bit acc;
    acc = iss_valid && exp_rdy() && (iss_dst != 5'd0);
    if (we && wa != 5'd0) begin
      regs_m[wa] = wd;
      if (cnt_m[wa] == 0) uf_m = 1'b1;
      else                cnt_m[wa]--;
    end
    if (acc) cnt_m[iss_dst]++;
    @(posedge clk);
    #1;
    chk("err_underflow", {31'd0, err_underflow}, {31'd0, uf_m});
  endtask

  task automatic step(input logic [4:0] a1, input logic [4:0] a2,
                      input logic w, input logic [4:0] waddr, input logic [31:0] wdata,
                      input logic iv, input logic [4:0] dst);
    apply(a1, a2, w, waddr, wdata, iv, dst);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ra1 = 5'd5; ra2 = 5'd31; we = 1'b1; wa = 5'd5; wd = 32'hCAFEF00D;
    iss_valid = 1'b1; iss_dst = 5'd9;
    #1;
    chk("rst_rd1", rd1, 32'd0);
    chk("rst_rd2", rd2, 32'd0);
    chk("rst_haz1", {31'd0, haz1}, 32'd0);
    chk("rst_haz2", {31'd0, haz2}, 32'd0);
    chk("rst_iss_ready", {31'd0, iss_ready}, 32'd1);
    chk("rst_err", {31'd0, err_underflow}, 32'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    we = 1'b0; iss_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    ra1 = '0; ra2 = '0; we = 1'b0; wa = '0; wd = '0; iss_valid = 1'b0; iss_dst = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Dirty some state, then reset mid-run and confirm everything clears.
    step(5'd3, 5'd31, 1'b1, 5'd3, 32'h11112222, 1'b1, 5'd31);
    step(5'd3, 5'd31, 1'b1, 5'd31, 32'h33334444, 1'b0, 5'd0);
    do_reset();
    apply(5'd3, 5'd31, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("post_rst_rd1_r3", rd1, 32'd0);
    chk("post_rst_rd2_r31", rd2, 32'd0);
    tick();

    // Zero register: write dropped, not a retire.
    step(5'd0, 5'd0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0);
    apply(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("zero_rd1", rd1, 32'd0);
    chk("zero_err", {31'd0, err_underflow}, 32'd0);
    tick();

    // Basic write with same-cycle bypass.
    apply(5'd5, 5'd0, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0);
    chk("bypass_rd1", rd1, 32'h12345678);
    tick();
    apply(5'd5, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("stored_rd1", rd1, 32'h12345678);
    tick();

    // Hazard lifecycle on r7.
    step(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    apply(5'd7, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("life_haz1_set", {31'd0, haz1}, 32'd1);
    tick();
    apply(5'd7, 5'd0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0);
    chk("life_haz1_fwd", {31'd0, haz1}, 32'd0);
    chk("life_rd1_fwd", rd1, 32'hA5A5A5A5);
    tick();
    apply(5'd7, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    chk("life_haz1_clear", {31'd0, haz1}, 32'd0);
    chk("life_ready", {31'd0, iss_ready}, 32'd1);
    iss_valid = 1'b0;
    @(posedge clk); #1;

    // Saturation on r9.
    repeat (3) step(5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    apply(5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    chk("sat_not_ready", {31'd0, iss_ready}, 32'd0);
    tick();
    apply(5'd9, 5'd0, 1'b1, 5'd9, 32'h00000009, 1'b1, 5'd9);
    chk("sat_ready_with_retire", {31'd0, iss_ready}, 32'd1);
    tick();
    apply(5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    chk("sat_still_full", {31'd0, iss_ready}, 32'd0);
    tick();
    repeat (3) step(5'd9, 5'd0, 1'b1, 5'd9, 32'h99990000, 1'b0, 5'd0);
    apply(5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("sat_haz_clear", {31'd0, haz1}, 32'd0);
    tick();

    // Concurrent issue r2 / retire r3 (cnt[3] starts at 2).
    step(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    step(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    step(5'd2, 5'd3, 1'b1, 5'd3, 32'h33330003, 1'b1, 5'd2);
    apply(5'd2, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("conc_haz1", {31'd0, haz1}, 32'd1);
    chk("conc_haz2", {31'd0, haz2}, 32'd1);
    tick();
    step(5'd2, 5'd3, 1'b1, 5'd3, 32'h33330004, 1'b0, 5'd0);
    step(5'd2, 5'd3, 1'b1, 5'd2, 32'h22220002, 1'b0, 5'd0);

    // Underflow on r4: data still written, flag sticky.
    step(5'd4, 5'd0, 1'b1, 5'd4, 32'h44440004, 1'b0, 5'd0);
    chk("uf_set", {31'd0, err_underflow}, 32'd1);
    apply(5'd4, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("uf_rd_r4", rd1, 32'h44440004);
    tick();
    repeat (3) step(5'd1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("uf_sticky", {31'd0, err_underflow}, 32'd1);

    // Randomised traffic over a small register window to force collisions.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [4:0] r1, r2, w, d;
      r1 = 5'($urandom_range(7));
      r2 = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
      w  = 5'($urandom_range(7));
      d  = 5'($urandom_range(7));
      step(r1, r2, ($urandom_range(9) < 4), w, $urandom,
           ($urandom_range(9) < 6), d);
    end

    do_reset();
    apply(5'd4, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd9);
    chk("final_err_clear", {31'd0, err_underflow}, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
